prbs_seq_gen_det: RTL and testbench

//  Parametrised pattern/PRBS-15 source with an in-line sequence detector.

---
 rtl/prbs_seq_pkg.sv | 23 ++
 rtl/prbs15_step.sv | 25 ++
 rtl/prbs_seq_gen_det.sv | 221 ++++++++++++++++++++++
 tb/tb_prbs_seq_gen_det.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_seq_pkg.sv
// Shared types and constants for the pattern / PRBS-15 source.
package prbs_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PATTERN = 2'd2,
    PRBS    = 2'd3
  } state_t;

  // x^15 + x^14 + 1: feedback taps on the two top bits of the shift register
  localparam int PRBS_ORDER  = 15;
  localparam int PRBS_TAP_HI = 14;
  localparam int PRBS_TAP_LO = 13;

  localparam logic [PRBS_ORDER-1:0] PRBS_DEFAULT_SEED = 15'h7FFF;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1
  function automatic logic [PRBS_ORDER-1:0] prbs_fix_seed(input logic [PRBS_ORDER-1:0] seed);
    return (seed == '0) ? 15'h0001 : seed;
  endfunction

endpackage

// File: rtl/prbs15_step.sv
// Combinational PRBS-15 advance: DATA_W shift steps, first bit lands in the word MSB.
module prbs15_step
  import prbs_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [PRBS_ORDER-1:0] state_in,
  output logic [PRBS_ORDER-1:0] state_out,
  output logic [DATA_W-1:0]     word_out
);

  logic [PRBS_ORDER-1:0] s;

  // Unrolled shift chain; each step emits the top bit and feeds back the tap XOR
  always_comb begin
    s        = state_in;
    word_out = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      word_out = (word_out << 1) | DATA_W'(s[PRBS_TAP_HI]);
      s        = {s[PRBS_ORDER-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    end
    state_out = s;
  end

endmodule

// File: rtl/prbs_seq_gen_det.sv
// Pattern / PRBS-15 source with in-line sequence detector.
// Optional: define PRBS_ERR_INJECT_EN to add the err_inject input (bit-0 corruption).
module prbs_seq_gen_det
  import prbs_seq_pkg::*;
#(
  parameter int                    DATA_W    = 8,
  parameter int                    PAT_LEN   = 4,
  parameter int                    REP_W     = 2,
  parameter logic [PRBS_ORDER-1:0] PRBS_SEED = PRBS_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REP_W-1:0]  rep_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] data_in,
`ifdef PRBS_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_flag,
  output logic              busy
);

  localparam int                    IDX_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(PAT_LEN - 1);
  localparam logic [PRBS_ORDER-1:0] SEED     = prbs_fix_seed(PRBS_SEED);

  state_t                state, state_nx;
  logic [DATA_W-1:0]     pat [PAT_LEN];
  logic [IDX_W-1:0]      idx, idx_nx, idx_inc;
  logic [REP_W-1:0]      rep, rep_nx, rep_n_q, rep_n_nx;
  logic [PRBS_ORDER-1:0] lfsr, lfsr_nx;
  logic                  out_valid_nx, busy_nx, flag_nx;
  logic [DATA_W-1:0]     data_out_nx;
  logic                  accept, restart, new_word;
  logic                  err_in, err_pend, err_pend_nx;
  logic [DATA_W-1:0]     err_mask;

  logic [IDX_W-1:0]      midx, midx_nx, b_idx;
  logic [REP_W-1:0]      mrep, mrep_nx, b_rep;
  logic                  hit;

  logic [PRBS_ORDER-1:0] step_in, step_state;
  logic [DATA_W-1:0]     step_word;

`ifdef PRBS_ERR_INJECT_EN
  assign err_in = err_inject;
`else
  assign err_in = 1'b0;
`endif

  assign accept   = out_valid && out_ready;
  assign restart  = start && (state == IDLE || state == PRBS);
  assign idx_inc  = idx + 1'b1;
  // A pending or same-cycle error pulse corrupts the next word loaded into data_out
  assign err_mask = DATA_W'(err_pend | err_in);
  // Entering PRBS always restarts from the seed; inside PRBS the stream continues
  assign step_in  = (state == PRBS) ? lfsr : SEED;

  prbs15_step #(.DATA_W(DATA_W)) u_step (
    .state_in  (step_in),
    .state_out (step_state),
    .word_out  (step_word)
  );

  // Pattern capture; deliberately outside reset so the pattern survives rst
  always_ff @(posedge clk) begin
    if (state == LOAD && load_valid) pat[idx] <= data_in;
  end

  // Main FSM and output-register next-state
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    rep_nx       = rep;
    rep_n_nx     = rep_n_q;
    lfsr_nx      = lfsr;
    out_valid_nx = out_valid;
    data_out_nx  = data_out;
    new_word     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          rep_n_nx = rep_n;
          idx_nx   = '0;
          rep_nx   = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          if (idx == LAST_IDX) begin
            idx_nx       = '0;
            rep_nx       = '0;
            out_valid_nx = 1'b1;
            new_word     = 1'b1;
            if (rep_n_q == '0) begin
              state_nx    = PRBS;
              lfsr_nx     = step_state;
              data_out_nx = step_word ^ err_mask;
            end else begin
              state_nx    = PATTERN;
              // pat[0] is still being written when PAT_LEN is 1
              data_out_nx = ((idx == '0) ? data_in : pat[0]) ^ err_mask;
            end
          end else begin
            idx_nx = idx_inc;
          end
        end
      end
      PATTERN: begin
        if (accept) begin
          new_word = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nx = '0;
            if (({1'b0, rep} + 1'b1) == {1'b0, rep_n_q}) begin
              state_nx    = PRBS;
              rep_nx      = '0;
              lfsr_nx     = step_state;
              data_out_nx = step_word ^ err_mask;
            end else begin
              rep_nx      = rep + 1'b1;
              data_out_nx = pat[0] ^ err_mask;
            end
          end else begin
            idx_nx      = idx_inc;
            data_out_nx = pat[idx_inc] ^ err_mask;
          end
        end
      end
      PRBS: begin
        if (start) begin
          state_nx     = LOAD;
          rep_n_nx     = rep_n;
          idx_nx       = '0;
          rep_nx       = '0;
          out_valid_nx = 1'b0;
        end else if (accept) begin
          new_word    = 1'b1;
          lfsr_nx     = step_state;
          data_out_nx = step_word ^ err_mask;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx     = (state_nx != IDLE);
    err_pend_nx = new_word ? 1'b0 : (err_pend | err_in);
  end

  // Detector: a mismatching word may itself restart the match at pattern position 0
  always_comb begin
    midx_nx = midx;
    mrep_nx = mrep;
    flag_nx = 1'b0;
    b_idx   = '0;
    b_rep   = '0;
    hit     = 1'b0;
    if (restart) begin
      midx_nx = '0;
      mrep_nx = '0;
    end else if (accept && rep_n_q != '0) begin
      if (data_out == pat[midx]) begin
        b_idx = midx;
        b_rep = mrep;
        hit   = 1'b1;
      end else if (data_out == pat[0]) begin
        hit   = 1'b1;
      end
      if (!hit) begin
        midx_nx = '0;
        mrep_nx = '0;
      end else if (b_idx == LAST_IDX) begin
        midx_nx = '0;
        if (({1'b0, b_rep} + 1'b1) == {1'b0, rep_n_q}) begin
          flag_nx = 1'b1;
          mrep_nx = '0;
        end else begin
          mrep_nx = b_rep + 1'b1;
        end
      end else begin
        midx_nx = b_idx + 1'b1;
        mrep_nx = b_rep;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      rep       <= '0;
      rep_n_q   <= '0;
      lfsr      <= SEED;
      out_valid <= 1'b0;
      data_out  <= '0;
      data_flag <= 1'b0;
      busy      <= 1'b0;
      midx      <= '0;
      mrep      <= '0;
      err_pend  <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      rep       <= rep_nx;
      rep_n_q   <= rep_n_nx;
      lfsr      <= lfsr_nx;
      out_valid <= out_valid_nx;
      data_out  <= data_out_nx;
      data_flag <= flag_nx;
      busy      <= busy_nx;
      midx      <= midx_nx;
      mrep      <= mrep_nx;
      err_pend  <= err_pend_nx;
    end
  end

endmodule

// File: tb/tb_prbs_seq_gen_det.sv
// Self-checking bench for prbs_seq_gen_det (DATA_W=8, PAT_LEN=4, seed 7FFF).
module tb_prbs_seq_gen_det;

  logic       clk = 1'b0;
  logic       rst, start, load_valid, out_ready, err_inject;
  logic [1:0] rep_n;
  logic [7:0] data_in;
  logic       out_valid, data_flag, busy;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  prbs_seq_gen_det #(
    .DATA_W    (8),
    .PAT_LEN   (4),
    .REP_W     (2),
    .PRBS_SEED (15'h7FFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rep_n      (rep_n),
    .load_valid (load_valid),
    .data_in    (data_in),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject (err_inject),
`endif
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .data_out   (data_out),
    .data_flag  (data_flag),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_LOAD, M_STREAM} mmode_t;
  mmode_t     mode;
  logic [7:0] m_pat [4];
  int         m_rep, ld_cnt, pat_left, prbs_k, matched, flag_pulses;
  logic [7:0] exp_q [$];
  logic [7:0] acc_log [$];
  int         obits [$];
  logic       exp_flag;

  // PRBS-15 output bits obey o[n] = o[n-15] ^ o[n-14]; first 15 bits are the seed, MSB first
  function automatic logic [7:0] prbs_word(input int k);
    logic [14:0] seed_v = 15'h7FFF;
    logic [7:0]  w = '0;
    if (obits.size() == 0)
      for (int i = 0; i < 15; i++) obits.push_back(int'(seed_v[14-i]));
    while (obits.size() < 8*k + 8)
      obits.push_back(obits[obits.size()-15] ^ obits[obits.size()-14]);
    for (int i = 0; i < 8; i++) w = {w[6:0], obits[8*k+i][0]};
    return w;
  endfunction

  task automatic model_reset();
    mode     = M_IDLE;
    exp_q.delete();
    exp_flag = 1'b0;
    matched  = 0;
    pat_left = 0;
  endtask

  // Detector as a position counter over the target stream (pattern repeated m_rep times)
  task automatic detect(input logic [7:0] w);
    if (m_rep == 0) return;
    if (w == m_pat[matched % 4]) matched++;
    else matched = (w == m_pat[0]) ? 1 : 0;
    if (matched == 4 * m_rep) begin
      exp_flag = 1'b1;
      matched  = 0;
    end
  endtask

  // One clock: check outputs at the falling edge, then drive inputs for the next rising edge
  task automatic cycle(input logic s, input logic [1:0] r, input logic lv, input logic [7:0] d,
                       input logic rdy, input logic rs, input logic er);
    logic [7:0] w, tmp;
    logic       acc = 1'b0;
    @(negedge clk);
    check("data_flag", data_flag, exp_flag);
    check("busy", busy, mode != M_IDLE);
    if (data_flag) flag_pulses++;
    if (mode == M_STREAM) begin
      check("out_valid", out_valid, 1);
      check("data_out", data_out, exp_q[0]);
    end else begin
      check("out_valid", out_valid, 0);
    end
    rst = rs; start = s; rep_n = r; load_valid = lv; data_in = d; out_ready = rdy; err_inject = er;
    exp_flag = 1'b0;
    if (rs) begin
      model_reset();
      return;
    end
    case (mode)
      M_IDLE: if (s) begin mode = M_LOAD; m_rep = int'(r); ld_cnt = 0; end
      M_LOAD: if (lv) begin
        m_pat[ld_cnt] = d;
        ld_cnt++;
        if (ld_cnt == 4) begin
          mode = M_STREAM;
          exp_q.delete();
          for (int k = 0; k < m_rep; k++)
            for (int j = 0; j < 4; j++) exp_q.push_back(m_pat[j]);
          pat_left = 4 * m_rep;
          prbs_k   = 0;
          matched  = 0;
        end
      end
      M_STREAM: begin
        if (s && pat_left == 0) begin
          mode = M_LOAD; m_rep = int'(r); ld_cnt = 0;
        end else if (rdy) begin
          acc = 1'b1;
          acc_log.push_back(data_out);
          w = exp_q.pop_front();
          if (pat_left > 0) pat_left--;
          detect(w);
        end
      end
      default: ;
    endcase
    if (mode == M_STREAM) begin
      while (exp_q.size() < 2) begin
        exp_q.push_back(prbs_word(prbs_k));
        prbs_k++;
      end
      if (er) begin
        tmp = acc ? exp_q[0] : exp_q[1];
        tmp[0] = ~tmp[0];
        if (acc) exp_q[0] = tmp; else exp_q[1] = tmp;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic load_pat(input logic [1:0] r, input logic [31:0] pw, input bit gaps);
    int n = 0, guard = 0;
    logic lv;
    cycle(1'b1, r, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    while (n < 4 && guard < 40) begin
      lv = gaps ? ($urandom % 3 != 0) : 1'b1;
      cycle(gaps && ($urandom % 4 == 0), 2'($urandom), lv,
            lv ? pw[31-8*n -: 8] : 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (lv) n++;
      guard++;
    end
    if (n < 4) begin
      errors++;
      $display("FAIL load_bound loaded=%0d need=4", n);
    end
  endtask

  task automatic stream(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      cycle(rnd && pat_left > 0 && ($urandom % 8 == 0), 2'($urandom), 1'b0, 8'h00,
            rnd ? ($urandom % 4 != 0) : 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (mode == M_STREAM && pat_left > 0 && guard < 100) begin
      cycle(1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    if (guard >= 100) begin
      errors++;
      $display("FAIL drain_bound left=%0d need=0", pat_left);
    end
  endtask

  task automatic check_log(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int i = 0; i < 3; i++)
      check(tag, (acc_log.size() > i) ? acc_log[i] : 8'hxx, e[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] dir_exp [11];
    logic [31:0] pw;
    dir_exp = '{8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hFF, 8'hFE, 8'h00};
    rst = 1'b1; start = 1'b0; rep_n = '0; load_valid = 1'b0; data_in = '0;
    out_ready = 1'b0; err_inject = 1'b0;
    flag_pulses = 0;
    model_reset();
    @(posedge clk);
    cycle(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("reset_data_out", data_out, 8'h00);

    // Pattern x2 then PRBS, continuous ready
    load_pat(2'd2, 32'hCCDDEEFF, 1'b0);
    acc_log.delete();
    flag_pulses = 0;
    stream(31, 1'b0);
    for (int i = 0; i < 11; i++) check("dir_word", acc_log[i], dir_exp[i]);
    check("flag_pulses", flag_pulses, 1);

    // Backpressure at word DD
    load_pat(2'd2, 32'hCCDDEEFF, 1'b0);
    stream(1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    acc_log.delete();
    stream(3, 1'b0);
    check_log("bp_words", 8'hDD, 8'hEE, 8'hFF);

    // Reset while EE is presented, then restart from IDLE
    drain();
    load_pat(2'd1, 32'hCCDDEEFF, 1'b0);
    stream(2, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_mid_data_out", data_out, 8'h00);
    load_pat(2'd1, 32'h01020304, 1'b0);
    acc_log.delete();
    stream(12, 1'b0);
    check_log("restart_words", 8'h01, 8'h02, 8'h03);

    // rep_n = 0: straight to PRBS, detector silent
    drain();
    load_pat(2'd0, 32'hFFFEFE00, 1'b0);
    acc_log.delete();
    flag_pulses = 0;
    stream(20, 1'b0);
    check_log("rep0_words", 8'hFF, 8'hFE, 8'h00);
    check("rep0_flag_pulses", flag_pulses, 0);

`ifdef PRBS_ERR_INJECT_EN
    load_pat(2'd0, 32'h11223344, 1'b0);
    cycle(1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    acc_log.delete();
    stream(3, 1'b0);
    check_log("err_words", 8'hFF, 8'hFF, 8'h00);
`endif

    // Randomised rounds over a two-symbol alphabet to exercise detector restarts
    for (int round = 0; round < 25; round++) begin
      drain();
      for (int j = 0; j < 4; j++) pw[31-8*j -: 8] = ($urandom % 2) ? 8'h5A : 8'hA5;
      load_pat(2'($urandom), pw, 1'b1);
      stream(20 + int'($urandom % 40), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
